// File: rtl/cpu_run_monitor.sv
// Run sequencer for the CPU (go -> ARM -> RUN for MAXCYCLES -> DONE) plus out-word capture FIFO.
// Define MON_TIMESTAMP_EN to add rd_stamp: the RUN cycle count stored with each captured word.
module cpu_run_monitor #(
  parameter int WIDTH       = 36,
  parameter int DEPTH       = 16,
  parameter int MAXCYCLES   = 1000,
  parameter int START_DELAY = 1,
  parameter int CYCW        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       outFlag,
  input  logic [WIDTH-1:0]           out,
  output logic                       startIO,
  output logic                       running,
  output logic                       done,
  output logic [CYCW-1:0]            cycles,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`ifdef MON_TIMESTAMP_EN
  ,
  output logic [CYCW-1:0]            rd_stamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = $clog2(START_DELAY+1);

  localparam logic [CYCW-1:0] CYC_LAST = CYCW'(MAXCYCLES-1);
  localparam logic [DW-1:0]   ARM_LAST = DW'(START_DELAY-1);
  localparam logic [LW-1:0]   LVL_FULL = LW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [DW-1:0] arm_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      arm_cnt <= '0;
      cycles  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            state   <= ARM;
            arm_cnt <= '0;
            cycles  <= '0;
          end
        end
        ARM: begin
          if (arm_cnt == ARM_LAST) begin
            state <= RUN;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        RUN: begin
          // cycles freezes on the final RUN cycle
          if (cycles == CYC_LAST) begin
            state <= DONE;
          end else begin
            cycles <= cycles + 1'b1;
          end
        end
      endcase
    end
  end

  assign startIO = (state == RUN);
  assign running = (state == RUN);
  assign done    = (state == DONE);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level_n;
  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;

  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign capture = running && outFlag;
  assign pop     = rd_en && !empty;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    level_n = level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr] <= out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wptr     <= wptr + AW'(push);
      rptr     <= rptr + AW'(pop);
      level    <= level_n;
      empty    <= (level_n == '0);
      full     <= (level_n == LVL_FULL);
      overflow <= overflow | drop;
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rptr];
      end
    end
  end

`ifdef MON_TIMESTAMP_EN
  logic [CYCW-1:0] smem [DEPTH];

  always_ff @(posedge clock) begin
    if (push) begin
      smem[wptr] <= cycles;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_stamp <= '0;
    end else if (pop) begin
      rd_stamp <= smem[rptr];
    end
  end
`endif

endmodule
